// File: rtl/cle_pkg.sv
// Shared types and constants for the CLE key PAL read sequencer.
package cle_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StGap,
        StDone
    } cle_state_e;

    // {BA13,BA12} value that opens the PAL's decode window.
    localparam logic [1:0] CLE_BA_HI = 2'b01;

    localparam int unsigned STROBE_CYC_DEF = 2;
    localparam int unsigned SETUP_CYC_DEF  = 1;
    localparam int unsigned GAP_CYC_DEF    = 1;
    localparam int unsigned MAX_BITS_DEF   = 16;
    localparam int unsigned CNT_W          = 5;

    // Zero length means one read; anything past the response width is capped.
    function automatic logic [CNT_W-1:0] cle_clamp_len(input logic [CNT_W-1:0] len,
                                                       input int unsigned     max_bits);
        if (len == '0) begin
            return CNT_W'(1);
        end
        if (int'(len) > int'(max_bits)) begin
            return CNT_W'(max_bits);
        end
        return len;
    endfunction

endpackage

// File: rtl/cle_phase_timer.sv
// Loadable 4-bit down-counter with zero flag; times each read phase.
module cle_phase_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       zero_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/cle_key_reader.sv
// Issues timed SSER read strobes into the CLE key PAL and collects the SDRD
// bits into a right-aligned word returned over a valid/ready port.
module cle_key_reader
    import cle_pkg::*;
#(
    parameter int unsigned STROBE_CYC = STROBE_CYC_DEF,
    parameter int unsigned SETUP_CYC  = SETUP_CYC_DEF,
    parameter int unsigned GAP_CYC    = GAP_CYC_DEF,
    parameter int unsigned MAX_BITS   = MAX_BITS_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [CNT_W-1:0]    cmd_len_i,
    input  logic [3:0]          cmd_nib_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [MAX_BITS-1:0] rsp_data_o,
    output logic [1:0]          ba_hi_o,
    output logic [3:0]          ba_nib_o,
    output logic                sser_n_o,
    output logic                br_w_o,
    input  logic                sdrd_i
);

    cle_state_e          state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MAX_BITS-1:0] data_q, data_d;
    logic [3:0]          ba_nib_q, ba_nib_d;
    logic [1:0]          ba_hi_q, ba_hi_d;
    logic                sser_n_q, sser_n_d;
    logic                br_w_q, br_w_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic                tmr_load;
    logic [3:0]          tmr_val;
    logic                tmr_zero;

    cle_phase_timer u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        ba_nib_d = ba_nib_q;
        tmr_load = 1'b0;
        tmr_val  = 4'd0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    len_d    = cle_clamp_len(cmd_len_i, MAX_BITS);
                    ba_nib_d = cmd_nib_i;
                    cnt_d    = '0;
                    data_d   = '0;
                    state_d  = StSetup;
                    tmr_load = 1'b1;
                    tmr_val  = 4'(SETUP_CYC - 1);
                end
            end
            StSetup: begin
                if (tmr_zero) begin
                    state_d  = StStrobe;
                    tmr_load = 1'b1;
                    tmr_val  = 4'(STROBE_CYC - 1);
                end
            end
            StStrobe: begin
                if (tmr_zero) begin
                    data_d   = {data_q[MAX_BITS-2:0], sdrd_i};
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = StGap;
                    tmr_load = 1'b1;
                    tmr_val  = 4'(GAP_CYC - 1);
                end
            end
            StGap: begin
                if (tmr_zero) begin
                    if (cnt_q < len_q) begin
                        state_d  = StSetup;
                        tmr_load = 1'b1;
                        tmr_val  = 4'(SETUP_CYC - 1);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (rsp_valid_q && rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs follow the next state so every pin comes straight off a flop.
        sser_n_d    = (state_d != StStrobe);
        ba_hi_d     = (state_d == StSetup || state_d == StStrobe || state_d == StGap) ?
                      CLE_BA_HI : 2'b00;
        br_w_d      = 1'b1;
        cmd_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_q == StDone) && (state_d == StDone);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            ba_nib_q    <= 4'd0;
            ba_hi_q     <= 2'b00;
            sser_n_q    <= 1'b1;
            br_w_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            ba_nib_q    <= ba_nib_d;
            ba_hi_q     <= ba_hi_d;
            sser_n_q    <= sser_n_d;
            br_w_q      <= br_w_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = data_q;
    assign ba_hi_o     = ba_hi_q;
    assign ba_nib_o    = ba_nib_q;
    assign sser_n_o    = sser_n_q;
    assign br_w_o      = br_w_q;

endmodule

// File: tb/tb_cle_key_reader.sv
// Randomised and directed bench for cle_key_reader against a PAL bit-stream model.
module tb_cle_key_reader;

    localparam int unsigned BitCyc = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_len;
    logic [3:0]  cmd_nib;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  ba_hi;
    logic [3:0]  ba_nib;
    logic        sser_n;
    logic        br_w;
    logic        sdrd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cle_key_reader u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_len_i   (cmd_len),
        .cmd_nib_i   (cmd_nib),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .ba_hi_o     (ba_hi),
        .ba_nib_o    (ba_nib),
        .sser_n_o    (sser_n),
        .br_w_o      (br_w),
        .sdrd_i      (sdrd)
    );

    // PAL model: 64-entry output table walked one step per SSER low pulse.
    logic [63:0] rom;
    logic [5:0]  pal_seed;
    int          pal_adv = 0;
    always @(posedge sser_n) pal_adv <= pal_adv + 1;
    assign sdrd = rom[6'(pal_seed + 6'(pal_adv))];

    // Bus monitor.
    int         strobes = 0, glitches = 0, bad_addr = 0, bad_width = 0, low_w = 0;
    logic [3:0] exp_nib = 4'd0;
    logic       prev_sser = 1'b1;
    logic [1:0] prev_hi = 2'b00;
    logic [3:0] prev_nib = 4'd0;
    logic       mon_rst;
    always begin
        @(posedge clk);
        mon_rst = rst;
        #1;
        if (!mon_rst && sser_n !== prev_sser && (ba_hi !== prev_hi || ba_nib !== prev_nib))
            glitches++;
        if (sser_n === 1'b0) begin
            if (prev_sser === 1'b1) begin
                strobes++;
                low_w = 1;
            end else begin
                low_w++;
            end
            if (ba_hi !== 2'b01 || ba_nib !== exp_nib) bad_addr++;
        end else begin
            if (prev_sser === 1'b0 && !mon_rst && low_w != 2) bad_width++;
            low_w = 0;
        end
        prev_sser = sser_n;
        prev_hi   = ba_hi;
        prev_nib  = ba_nib;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_len(input logic [4:0] len);
        if (len == 5'd0) return 1;
        if (len > 5'd16) return 16;
        return int'(len);
    endfunction

    function automatic logic [15:0] ref_data(input int n, input logic [5:0] seed);
        logic [15:0] w = 16'h0;
        for (int i = 0; i < n; i++) w = {w[14:0], rom[6'(seed + 6'(i))]};
        return w;
    endfunction

    // One full command: accept, timing, data, optional back-pressure, handshake.
    task automatic run_cmd(input logic [4:0] len, input logic [3:0] nib, input logic [5:0] seed,
                           input int hold, input bit chain, output logic [15:0] got);
        int          n, k, w, s0, unstable;
        logic [15:0] exp;
        n        = ref_len(len);
        exp      = ref_data(n, seed);
        exp_nib  = nib;
        pal_seed = 6'(seed - 6'(pal_adv));
        s0       = strobes;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_nib   = nib;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", 32'(w < 100), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("busy_ready", 32'(cmd_ready), 32'd0);
        k = 0;
        do begin
            @(posedge clk);
            #1 k++;
        end while (!rsp_valid && k < 300);
        check("latency", k, n * BitCyc + 1);
        check("rsp_data", 32'(rsp_data), 32'(exp));
        check("strobes", strobes - s0, n);
        check("done_ba_hi", 32'(ba_hi), 32'd0);
        got = rsp_data;
        if (hold > 0) begin
            unstable = 0;
            if (chain) begin
                @(negedge clk);
                cmd_valid = 1'b1;
                cmd_len   = 5'd1;
                cmd_nib   = nib;
            end
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (rsp_data !== exp || rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
                    ba_hi !== 2'b00) unstable++;
            end
            check("hold_stable", unstable, 0);
            check("hold_strobes", strobes - s0, n);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("hs_valid", 32'(rsp_valid), 32'd0);
        check("hs_ready", 32'(cmd_ready), 32'd1);
        if (chain) begin
            check("chain_not_yet", 32'(ba_hi), 32'd0);
            pal_seed = 6'(seed - 6'(pal_adv));
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            check("chain_accept", 32'(ba_hi), 32'd1);
            k = 0;
            do begin
                @(posedge clk);
                #1 k++;
            end while (!rsp_valid && k < 300);
            check("chain_rsp", 32'(rsp_data), 32'(ref_data(1, seed)));
            @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
        check("glitches", glitches, 0);
        check("bad_addr", bad_addr, 0);
        check("bad_width", bad_width, 0);
        check("br_w", 32'(br_w), 32'd1);
    endtask

    initial begin
        logic [15:0] got;
        logic [7:0]  pat;
        int          s0, k, early;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = 5'd0;
        cmd_nib   = 4'd0;
        rsp_ready = 1'b0;
        rom       = '1;
        pal_seed  = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sser", 32'(sser_n), 32'd1);
        check("rst_brw", 32'(br_w), 32'd1);
        check("rst_ba", {26'd0, ba_hi, ba_nib}, 32'd0);
        check("rst_hs", {30'd0, cmd_ready, rsp_valid}, 32'd2);
        check("rst_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single read with SDRD held high.
        rom = '1;
        run_cmd(5'd1, 4'b0010, 6'd0, 0, 1'b0, got);
        check("len1_word", 32'(got), 32'h0001);

        // Eight reads of a seeded PAL sequence.
        rom = '0;
        pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) rom[6'(10 + i)] = pat[7 - i];
        run_cmd(5'd8, 4'b1010, 6'd10, 0, 1'b0, got);
        check("len8_word", 32'(got), 32'h00B2);

        // Length boundaries.
        rom = '1;
        run_cmd(5'd0, 4'h3, 6'd0, 0, 1'b0, got);
        check("len0_word", 32'(got), 32'h0001);
        run_cmd(5'd20, 4'h7, 6'd0, 0, 1'b0, got);
        check("len20_word", 32'(got), 32'hFFFF);

        // Back-pressure with a second command waiting.
        rom = {$urandom, $urandom};
        run_cmd(5'd5, 4'hC, 6'($urandom), 10, 1'b1, got);

        // Randomised commands.
        for (int t = 0; t < 25; t++) begin
            rom = {$urandom, $urandom};
            run_cmd(5'($urandom_range(0, 31)), 4'($urandom), 6'($urandom),
                    int'($urandom_range(0, 3)), 1'b0, got);
        end

        // Reset in the middle of the third strobe.
        exp_nib = 4'h9;
        s0 = strobes;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = 5'd8;
        cmd_nib   = 4'h9;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (strobes - s0 < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("third_strobe", strobes - s0, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_sser", 32'(sser_n), 32'd1);
        check("abort_ba_hi", 32'(ba_hi), 32'd0);
        check("abort_hs", {30'd0, cmd_ready, rsp_valid}, 32'd2);
        @(negedge clk);
        rst = 1'b0;
        early = 0;
        repeat (60) begin
            @(posedge clk);
            #1 if (rsp_valid) early++;
        end
        check("abort_no_rsp", early, 0);
        check("abort_strobes", strobes - s0, 3);
        check("abort_glitch", glitches, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
